// File: rtl/clip_indicator_pkg.sv
// Shared constants for the clip indicator: timer and blink counter widths, channel state encoding.
// No logic of its own; zero latency.
// No flow control; constants only.
package clip_indicator_pkg;

    // Hold timer width; HOLD_CYCLES must fit in this many bits.
    localparam int TIMER_W = 24;

    // Blink half-period counter width; BLINK_CYCLES must fit in this many bits.
    localparam int BLINK_W = 16;

    // Per-channel state: IDLE while the hold timer is zero, HOLD while it runs.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/clip_channel.sv
// One clip channel: overrange synchronizer, rising-edge detect, retriggerable hold timer, saturating event counter, sticky flag.
// LED rises 3 cycles after the async overrange input, event count visible 3 cycles after it.
// No backpressure; the run input gates timer loads and event counting.
module clip_channel
    import clip_indicator_pkg::*;
#(
    parameter int HOLD_CYCLES = 40000,
    parameter int CNT_W       = 8
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_run,
    input  logic             i_clear,
    input  logic             i_led_gate,
    input  logic             i_adc_overrange,
    output logic             o_led,
    output logic             o_clip_sticky,
    output logic [CNT_W-1:0] o_clip_count
);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_ovf_prev;
    logic [TIMER_W-1:0] r_timer;
    logic [CNT_W-1:0]   r_count;
    logic               r_sticky;

    logic               w_ovf;
    logic               w_event;
    logic               w_cnt_max;
    logic [0:0]         w_state;

    assign w_ovf     = r_sync2;
    // A clip is the first synced cycle of overrange; continuous overrange counts once.
    assign w_event   = w_ovf & ~r_ovf_prev & i_run;
    assign w_cnt_max = (r_count == {CNT_W{1'b1}});
    assign w_state   = (r_timer != '0) ? ST_HOLD : ST_IDLE;

    // Two-flop synchronizer bringing the asynchronous overrange flag into the clock domain.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_adc_overrange;
            r_sync2 <= r_sync1;
        end
    end

    // Edge detector history; keeps tracking even while stopped so a level already high at run start is not counted.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ovf_prev <= 1'b0;
        end else begin
            r_ovf_prev <= w_ovf;
        end
    end

    // Hold timer: reload on every overrange cycle, count down to zero otherwise, forced to zero when stopped.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_timer <= '0;
        end else if (!i_run) begin
            r_timer <= '0;
        end else if (w_ovf) begin
            r_timer <= TIMER_W'(HOLD_CYCLES);
        end else if (r_timer != '0) begin
            r_timer <= r_timer - TIMER_W'(1);
        end
    end

    // Saturating event counter and sticky flag; an event in the clear cycle wins, leaving count 1.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count  <= '0;
            r_sticky <= 1'b0;
        end else if (i_clear) begin
            r_count  <= w_event ? CNT_W'(1) : '0;
            r_sticky <= w_event;
        end else if (w_event) begin
            r_count  <= w_cnt_max ? r_count : r_count + CNT_W'(1);
            r_sticky <= 1'b1;
        end
    end

    assign o_led         = (w_state == ST_HOLD) & i_led_gate;
    assign o_clip_sticky = r_sticky;
    assign o_clip_count  = r_count;

endmodule

// File: rtl/clip_indicator.sv
// Multi-channel ADC clip indicator: per-channel hold LEDs (steady or blinking), sticky flags and saturating clip counters.
// LED asserts 3 cycles after an async overrange input; blink mode change applies the following cycle.
// No backpressure; run low blanks LEDs and ignores clips, clear zeroes counters and flags.
module clip_indicator
    import clip_indicator_pkg::*;
#(
    parameter int N_CH         = 2,
    parameter int HOLD_CYCLES  = 40000,
    parameter int BLINK_CYCLES = 5000,
    parameter int CNT_W        = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_run,
    input  logic                  i_blink_mode,
    input  logic                  i_clear,
    input  logic [N_CH-1:0]       i_adc_overrange,
    output logic [N_CH-1:0]       o_led,
    output logic                  o_led_any,
    output logic [N_CH-1:0]       o_clip_sticky,
    output logic [N_CH*CNT_W-1:0] o_clip_count
);

    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;
    logic               r_blink_mode;

    logic               w_led_gate;
    logic [N_CH-1:0]    w_led;

    // Free-running blink half-period counter, independent of channel activity.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + BLINK_W'(1);
        end
    end

    // Registered mode select so LED outputs depend on registers only; timers are untouched by mode changes.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_blink_mode <= 1'b0;
        end else begin
            r_blink_mode <= i_blink_mode;
        end
    end

    // Steady mode lights the LED for the whole hold; blink mode only during the high phase.
    assign w_led_gate = ~r_blink_mode | r_blink_phase;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clip_channel #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .CNT_W       (CNT_W)
        ) u_ch (
            .i_clock         (i_clock),
            .i_reset_n       (i_reset_n),
            .i_run           (i_run),
            .i_clear         (i_clear),
            .i_led_gate      (w_led_gate),
            .i_adc_overrange (i_adc_overrange[g]),
            .o_led           (w_led[g]),
            .o_clip_sticky   (o_clip_sticky[g]),
            .o_clip_count    (o_clip_count[g*CNT_W +: CNT_W])
        );
    end

    assign o_led     = w_led;
    assign o_led_any = |w_led;

endmodule

// File: tb/tb_clip_indicator.sv
// Self-checking bench for clip_indicator: directed table, multi-cycle corner sequences and random stimulus.
// Reference model works from input history: sync lag, last qualifying overrange within the hold window, event rules.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_clip_indicator;

    localparam int N_CH  = 2;
    localparam int HOLD  = 10;
    localparam int BLINK = 4;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int MAXC  = 4096;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  run = 1'b0;
    logic                  mode = 1'b0;
    logic                  clr = 1'b0;
    logic [N_CH-1:0]       adc = '0;
    logic [N_CH-1:0]       led;
    logic                  led_any;
    logic [N_CH-1:0]       sticky;
    logic [N_CH*CNT_W-1:0] cnt;

    clip_indicator #(
        .N_CH         (N_CH),
        .HOLD_CYCLES  (HOLD),
        .BLINK_CYCLES (BLINK),
        .CNT_W        (CNT_W)
    ) dut (
        .i_clock         (clk),
        .i_reset_n       (rst_n),
        .i_run           (run),
        .i_blink_mode    (mode),
        .i_clear         (clr),
        .i_adc_overrange (adc),
        .o_led           (led),
        .o_led_any       (led_any),
        .o_clip_sticky   (sticky),
        .o_clip_count    (cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Input history since the last reset release, indexed by cycle.
    logic [N_CH-1:0] in_h [MAXC];
    bit              run_h [MAXC];
    bit              mode_h [MAXC];
    bit              clr_h [MAXC];
    int              cyc;
    int              m_cnt [N_CH];
    bit              m_sticky [N_CH];

    logic [N_CH-1:0]       s_led;
    logic                  s_any;
    logic [N_CH-1:0]       s_sticky;
    logic [N_CH*CNT_W-1:0] s_cnt;

    typedef struct {
        logic [N_CH-1:0]       adc;
        logic [N_CH-1:0]       led;
        logic [N_CH*CNT_W-1:0] cnt;
        logic [N_CH-1:0]       sticky;
    } vec_t;
    vec_t tv [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Synced overrange seen by the design in cycle m is the raw input of cycle m-2.
    function automatic bit ovf_at(input int ch, input int m);
        if (m < 2) return 1'b0;
        return in_h[m-2][ch];
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int c = 0; c < N_CH; c++) begin
            m_cnt[c]    = 0;
            m_sticky[c] = 1'b0;
        end
    endtask

    task automatic model_check();
        logic [N_CH-1:0]       e_led;
        logic [N_CH*CNT_W-1:0] e_cnt;
        logic [N_CH-1:0]       e_st;
        bit                    phase;
        bit                    md;
        bit                    on;
        e_led = '0;
        e_cnt = '0;
        e_st  = '0;
        phase = ((cyc / BLINK) % 2) == 1;
        md    = (cyc > 0) ? mode_h[cyc-1] : 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            // Lit if an overrange with run high occurred within the last HOLD cycles and run never dropped since.
            on = 1'b0;
            for (int k = cyc - 1; k >= 0 && k >= cyc - HOLD; k--) begin
                if (!run_h[k]) break;
                if (ovf_at(c, k)) begin
                    on = 1'b1;
                    break;
                end
            end
            e_led[c] = on && (!md || phase);
            e_cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
            e_st[c]  = m_sticky[c];
        end
        chk("model_led", 32'(s_led), 32'(e_led));
        chk("model_led_any", 32'(s_any), 32'(|e_led));
        chk("model_count", 32'(s_cnt), 32'(e_cnt));
        chk("model_sticky", 32'(s_sticky), 32'(e_st));
    endtask

    task automatic step();
        bit ev;
        if (cyc >= MAXC - 1) begin
            $display("FAIL history_overflow: cycle %0d", cyc);
            $fatal(1, "history exhausted");
        end
        in_h[cyc]   = adc;
        run_h[cyc]  = run;
        mode_h[cyc] = mode;
        clr_h[cyc]  = clr;
        @(negedge clk);
        s_led    = led;
        s_any    = led_any;
        s_sticky = sticky;
        s_cnt    = cnt;
        model_check();
        @(posedge clk);
        for (int c = 0; c < N_CH; c++) begin
            ev = ovf_at(c, cyc) && !ovf_at(c, cyc - 1) && run_h[cyc];
            if (clr_h[cyc]) begin
                m_cnt[c]    = ev ? 1 : 0;
                m_sticky[c] = ev;
            end else if (ev) begin
                m_cnt[c]    = (m_cnt[c] < CMAX) ? m_cnt[c] + 1 : CMAX;
                m_sticky[c] = 1'b1;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        logic [N_CH*CNT_W-1:0] saved_cnt;

        // Single-cycle pulse on ch0 in cycle 2: LED on cycles 5..14, count 1 from cycle 5.
        for (int i = 0; i < 16; i++) begin
            tv[i].adc    = (i == 2) ? 2'b01 : 2'b00;
            tv[i].led    = (i >= 5 && i <= 14) ? 2'b01 : 2'b00;
            tv[i].cnt    = (i >= 5) ? 4'b0001 : 4'b0000;
            tv[i].sticky = (i >= 5) ? 2'b01 : 2'b00;
        end

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run   = 1'b1;

        for (int i = 0; i < 16; i++) begin
            adc = tv[i].adc;
            step();
            chk("tbl_led", 32'(s_led), 32'(tv[i].led));
            chk("tbl_count", 32'(s_cnt), 32'(tv[i].cnt));
            chk("tbl_sticky", 32'(s_sticky), 32'(tv[i].sticky));
        end

        // Sustained overrange on ch1 for 50 cycles: one event, LED continuous then 10-cycle tail.
        adc = 2'b10;
        repeat (50) step();
        adc = 2'b00;
        repeat (14) step();
        chk("hold50_count_once", 32'(s_cnt[3:2]), 32'd1);
        chk("hold50_led_off", 32'(s_led[1]), 32'd0);

        // Clear, then five separated pulses saturate at 3, then clear again.
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        chk("clear_count", 32'(s_cnt), 32'd0);
        for (int p = 1; p <= 5; p++) begin
            adc = 2'b01;
            step();
            adc = 2'b00;
            repeat (5) step();
            chk("sat_count", 32'(s_cnt[1:0]), 32'((p < CMAX) ? p : CMAX));
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        chk("clear2_count", 32'(s_cnt[1:0]), 32'd0);
        chk("clear2_sticky", 32'(s_sticky[0]), 32'd0);

        // Clear landing on the synced rising edge: event wins, count 1.
        for (int p = 0; p < 3; p++) begin
            adc = 2'b01;
            step();
            adc = 2'b00;
            repeat (3) step();
        end
        adc = 2'b01;
        step();
        adc = 2'b00;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        chk("clear_event_count", 32'(s_cnt[1:0]), 32'd1);
        chk("clear_event_sticky", 32'(s_sticky[0]), 32'd1);
        repeat (12) step();

        // Blink mode with sustained overrange, then run dropped mid-hold and restored with overrange still high.
        mode = 1'b1;
        adc  = 2'b11;
        repeat (30) step();
        saved_cnt = s_cnt;
        run = 1'b0;
        step();
        step();
        chk("run_off_led", 32'(s_led), 32'd0);
        run = 1'b1;
        repeat (10) step();
        chk("run_resume_no_event", 32'(s_cnt), 32'(saved_cnt));
        adc  = 2'b00;
        mode = 1'b0;
        repeat (15) step();

        // Random traffic against the reference model.
        for (int r = 0; r < 1500; r++) begin
            for (int c = 0; c < N_CH; c++)
                if ($urandom_range(0, 7) == 0) adc[c] = ~adc[c];
            if ($urandom_range(0, 63) == 0) run = ~run;
            if ($urandom_range(0, 99) == 0) mode = ~mode;
            clr = ($urandom_range(0, 49) == 0);
            step();
        end

        // Asynchronous reset in the middle of a hold.
        run  = 1'b1;
        mode = 1'b0;
        clr  = 1'b0;
        adc  = 2'b01;
        repeat (6) step();
        chk("pre_reset_led", 32'(s_led[0]), 32'd1);
        adc = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_led", 32'(led), 32'd0);
        chk("async_reset_led_any", 32'(led_any), 32'd0);
        chk("async_reset_sticky", 32'(sticky), 32'd0);
        chk("async_reset_count", 32'(cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (20) step();
        chk("post_reset_dark", 32'(s_led), 32'd0);
        adc = 2'b01;
        step();
        adc = 2'b00;
        repeat (14) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clip_indicator.md
CLIP_INDICATOR -- requirements
Module: clip_indicator

Interface
REQ-001 Parameter N_CH, default 2: number of independent ADC overrange channels, 1..8.
REQ-002 Parameter HOLD_CYCLES, default 40000: LED hold time in clock cycles (200 ms at 200 kHz tick), 1..2^24-1.
REQ-003 Parameter BLINK_CYCLES, default 5000: half-period of blink mode, in cycles, 1..2^16-1.
REQ-004 Parameter CNT_W, default 8: width of per-channel clip event counter.
REQ-005 clock  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 run  in  1  enable; low forces all LEDs off and all hold timers to zero.
REQ-008 blink_mode  in  1  0 = steady LED while holding, 1 = LED blinks while holding.
REQ-009 clear  in  1  synchronous one-cycle pulse; zeroes counters and sticky flags.
REQ-010 adc_overrange  in  N_CH  asynchronous overrange flags, one per channel.
REQ-011 led  out  N_CH  per-channel clip LED drive.
REQ-012 led_any  out  1  OR of all led bits.
REQ-013 clip_sticky  out  N_CH  per-channel flag, set on any clip, held until clear.
REQ-014 clip_count  out  N_CH*CNT_W  per-channel saturating clip event count, channel 0 in LSBs.

Function
REQ-015 Each adc_overrange bit SHALL pass a 2-flop synchronizer into clock domain; synced value ovf[i] lags input by 2 cycles.
REQ-016 Per channel, hold timer SHALL load HOLD_CYCLES on every cycle ovf[i]=1 and run=1 (retrigger), else decrement by 1 if nonzero, else hold at 0.
REQ-017 Channel state: IDLE (timer=0), HOLD (timer>0); IDLE->HOLD on ovf[i]; HOLD->IDLE when timer reaches 0 with ovf[i]=0; HOLD->HOLD reload on ovf[i].
REQ-018 Steady mode: led[i] = run & (timer[i]!=0); LED rises 1 cycle after ovf[i] rises, stays high exactly HOLD_CYCLES cycles after last cycle ovf[i]=1.
REQ-019 Blink mode: shared free-running counter toggles blink_phase every BLINK_CYCLES cycles; led[i] = run & HOLD & blink_phase; phase counter free-runs regardless of channel state.
REQ-020 blink_mode change SHALL take effect on the next cycle without disturbing timers.
REQ-021 Clip event = rising edge of ovf[i] (ovf[i]=1, previous=0) while run=1; continuous overrange counts once.
REQ-022 On clip event clip_count[i] SHALL increment by 1, saturating at 2^CNT_W-1 (no wrap).
REQ-023 On clip event clip_sticky[i] SHALL set to 1.
REQ-024 clear and clip event same cycle: event wins; count becomes 1, sticky stays 1.
REQ-025 run=0: timers forced 0, led=0, events ignored; counters and sticky retain values; edge detector still tracks ovf[i].
REQ-026 run rising while ovf[i] already high: no event counted until ovf[i] falls and rises again; timer loads immediately.
REQ-027 led_any SHALL be combinational OR of led; all other outputs registered or derived from registers only.

Reset
REQ-028 reset low SHALL asynchronously clear synchronizers, edge detectors, timers, blink counter, blink_phase, counters, sticky flags; led, led_any, clip_sticky, clip_count all 0.
REQ-029 Reset deassertion SHALL be used synchronously; first operational edge is the cycle after reset observed high.

Structure
REQ-030 Shared package holds timer width constant (24), blink counter width (16), and channel state encoding IDLE/HOLD.
REQ-031 One sub-module clip_channel (synchronizer, edge detect, timer, counter, sticky) instantiated N_CH times via generate; blink counter stays at top level.

Verification
REQ-032 HOLD_CYCLES=10, steady: 1-cycle pulse on ch0 -> led[0] high cycles 3..12 after pulse, count=1, sticky[0]=1, led[1]=0.
REQ-033 Overrange held 50 cycles -> led continuous, stays high 10 cycles after synced fall; count increments only once.
REQ-034 CNT_W=2: five separated pulses -> count 1,2,3,3,3; clear then count 0, sticky 0.
REQ-035 clear asserted same cycle as synced rising edge -> count=1, sticky=1 next cycle.
REQ-036 Blink mode, BLINK_CYCLES=4, sustained overrange -> led toggles every 4 cycles; led_any matches; run=0 mid-hold -> led 0 next cycle, count unchanged.
REQ-037 reset pulled low mid-hold, asynchronous to clock -> all outputs 0 without clock edge; after release no LED until new overrange.
